wb_port_arbiter: RTL

- Owns the single register-file write port shared by the ALU (1-cycle), the fixed-latency EX pipeline (ex1..ex5) and the MEM unit (variable latency).
- Tracks future EX write-port reservations in a shift vector and arbitrates same-cycle writeback requests.
- Drives the write-back permission and look-ahead signals consumed by the hazard unit: ex_allowed_wb, alu_allowed_wb, wb_is_next_cycle.
- Registers the winning write into the register-file write port.

---
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: owns the single register-file write port shared
// by the ALU, the fixed-latency EX pipeline and the MEM unit. Tracks future
// EX write reservations, arbitrates MEM > EX > ALU, and registers the winner.
module wb_port_arbiter #(
  // Matches the core's register index width (params_pkg::REGISTER_WIDTH).
  parameter int REGISTER_WIDTH = 5,
  // Cycles from ex_issue_i to the ex5 writeback request; must be >= 2 so
  // that the one-cycle look-ahead bit exists.
  parameter int EX_LATENCY     = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ex_issue_i,
  input  logic                      alu_wb_req_i,
  input  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i,
  input  logic                      ex5_valid_i,
  input  logic                      ex5_reg_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0] ex5_wr_reg_i,
  input  logic                      mem_wb_req_i,
  input  logic [REGISTER_WIDTH-1:0] mem_wr_reg_i,
  output logic                      ex_allowed_wb_o,
  output logic                      alu_allowed_wb_o,
  output logic                      mem_allowed_wb_o,
  output logic                      wb_is_next_cycle_o,
  output logic                      rf_we_o,
  output logic [REGISTER_WIDTH-1:0] rf_waddr_o,
  output logic [1:0]                rf_src_o,
  output logic                      proto_err_o,
  output logic [CNT_WIDTH-1:0]      wb_conflict_cnt_o
);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_EX   = 2'd2;
  localparam logic [1:0] SRC_MEM  = 2'd3;

  // rsv[k] set: an EX write is expected k cycles from now.
  logic [EX_LATENCY-1:0]     rsv;
  logic                      ex_req;
  logic                      ex_stall;
  logic                      conflict;
  logic                      proto_viol;
  logic [1:0]                win_src;
  logic [REGISTER_WIDTH-1:0] win_reg;

  // Request decode and same-cycle grants; MEM can never be held off.
  always_comb begin
    ex_req           = ex5_valid_i & ex5_reg_wr_en_i;
    mem_allowed_wb_o = 1'b1;
    ex_allowed_wb_o  = !(ex_req & mem_wb_req_i);
    alu_allowed_wb_o = !(alu_wb_req_i & (mem_wb_req_i | ex_req));
    ex_stall         = ex5_valid_i & !ex_allowed_wb_o;
    conflict         = (ex_req & mem_wb_req_i) | (alu_wb_req_i & !alu_allowed_wb_o);
    // A late/missing ex5 relative to its reservation, or an issue while
    // the EX pipe is frozen, means the hazard unit lost track.
    proto_viol       = (ex_req & !rsv[0])
                     | (rsv[0] & !ex5_valid_i & !ex_stall)
                     | (ex_issue_i & ex_stall);
  end

  // Fixed-priority winner selection: MEM > EX > ALU.
  always_comb begin
    win_src = SRC_NONE;
    win_reg = '0;
    if (mem_wb_req_i) begin
      win_src = SRC_MEM;
      win_reg = mem_wr_reg_i;
    end else if (ex_req) begin
      win_src = SRC_EX;
      win_reg = ex5_wr_reg_i;
    end else if (alu_wb_req_i) begin
      win_src = SRC_ALU;
      win_reg = alu_wr_reg_i;
    end
  end

  // Reservation shift vector; frozen together with the EX pipeline on a stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv <= '0;
    end else if (!ex_stall) begin
      rsv <= {ex_issue_i, rsv[EX_LATENCY-1:1]};
    end
  end

  // Look-ahead for the hazard unit; purely from state, no input path.
  assign wb_is_next_cycle_o = rsv[1];

  // Register-file write port; x0 is granted but never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_src_o   <= SRC_NONE;
    end else begin
      rf_src_o <= win_src;
      rf_we_o  <= (win_src != SRC_NONE) && (win_reg != '0);
      if (win_src != SRC_NONE) begin
        rf_waddr_o <= win_reg;
      end
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_o <= 1'b0;
    end else if (proto_viol) begin
      proto_err_o <= 1'b1;
    end
  end

  // Saturating count of cycles in which some requester was denied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_conflict_cnt_o <= '0;
    end else if (conflict && (wb_conflict_cnt_o != '1)) begin
      wb_conflict_cnt_o <= wb_conflict_cnt_o + 1'b1;
    end
  end

endmodule
